// File: rtl/input_ctrl_pkg.sv
// Shared types and parameter defaults for the systolic-array input feed controller.
package input_ctrl_pkg;

  localparam int unsigned DefaultN    = 32;
  localparam int unsigned DefaultCntW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StDrain,
    StDone
  } feed_state_t;

endpackage

// File: rtl/feed_counter.sv
// Up-counter with synchronous clear, enable, and a compare against a terminal value.
module feed_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last_val,
  output logic [CNT_W-1:0] count,
  output logic             at_last
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_last = (count_q == last_val);

endmodule

// File: rtl/input_feed_ctrl.sv
// Feeds num_rows upstream rows into the input array, then zero-fills to flush the skew buffers.
module input_feed_ctrl
  import input_ctrl_pkg::*;
#(
  parameter int unsigned N            = DefaultN,
  parameter int unsigned CNT_W        = DefaultCntW,
  parameter int unsigned DRAIN_CYCLES = N - 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rows,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             stall,
  output logic             fifo_en,
  output logic             feed_zero,
  output logic             busy,
  output logic             tile_done,
  output logic [CNT_W-1:0] rows_fed
);

  localparam logic [CNT_W-1:0] DrainLast =
    (DRAIN_CYCLES == 0) ? '0 : CNT_W'(DRAIN_CYCLES - 1);

  feed_state_t      state_q, state_d;
  logic [CNT_W-1:0] num_rows_q, num_rows_d;
  logic             tile_done_q, tile_done_d;

  logic             cnt_clr;
  logic             row_en, row_last;
  logic             drain_en, drain_last;
  logic [CNT_W-1:0] row_cnt, drain_cnt;
  logic             unused_drain_cnt;

  feed_counter #(
    .CNT_W(CNT_W)
  ) u_row_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (cnt_clr),
    .en      (row_en),
    .last_val(num_rows_q - CNT_W'(1)),
    .count   (row_cnt),
    .at_last (row_last)
  );

  feed_counter #(
    .CNT_W(CNT_W)
  ) u_drain_cnt (
    .clk     (clk),
    .nrst    (nrst),
    .clr     (cnt_clr),
    .en      (drain_en),
    .last_val(DrainLast),
    .count   (drain_cnt),
    .at_last (drain_last)
  );

  assign unused_drain_cnt = ^drain_cnt;

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    in_ready   = 1'b0;
    fifo_en    = 1'b0;
    feed_zero  = 1'b0;
    cnt_clr    = 1'b0;
    row_en     = 1'b0;
    drain_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_rows_d = num_rows;
          cnt_clr    = 1'b1;
          state_d    = (num_rows == '0) ? StDone : StFeed;
        end
      end
      StFeed: begin
        in_ready = !stall;
        fifo_en  = in_valid && !stall;
        row_en   = fifo_en;
        if (fifo_en && row_last) begin
          state_d = (DRAIN_CYCLES == 0) ? StDone : StDrain;
        end
      end
      StDrain: begin
        feed_zero = 1'b1;
        fifo_en   = !stall;
        drain_en  = fifo_en;
        if (fifo_en && drain_last) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered pulse aligned with the single DONE cycle.
  assign tile_done_d = (state_d == StDone);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      num_rows_q  <= '0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_rows_q  <= num_rows_d;
      tile_done_q <= tile_done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign tile_done = tile_done_q;
  assign rows_fed  = row_cnt;

endmodule

// File: tb/tb_input_feed_ctrl.sv
// Self-checking bench for input_feed_ctrl: per-cycle reference model plus directed tile scenarios.
module tb_input_feed_ctrl;

  localparam int unsigned N     = 32;
  localparam int unsigned CNT_W = 16;
  localparam int          DRAIN = N - 1;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_rows = '0;
  logic             in_valid = 1'b0;
  logic             stall = 1'b0;
  logic             in_ready, fifo_en, feed_zero, busy, tile_done;
  logic [CNT_W-1:0] rows_fed;

  int checks = 0;
  int errors = 0;

  input_feed_ctrl #(
    .N    (N),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .start    (start),
    .num_rows (num_rows),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .stall    (stall),
    .fifo_en  (fifo_en),
    .feed_zero(feed_zero),
    .busy     (busy),
    .tile_done(tile_done),
    .rows_fed (rows_fed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a tile is rows still owed, then zero-fill cycles still owed, then a done pulse.
  bit m_active, m_done;
  int m_rows_left, m_drain_left, m_rows_fed;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_active     <= 1'b0;
      m_done       <= 1'b0;
      m_rows_left  <= 0;
      m_drain_left <= 0;
      m_rows_fed   <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_rows_fed <= 0;
        if (num_rows == 0) begin
          m_done <= 1'b1;
        end else begin
          m_active     <= 1'b1;
          m_rows_left  <= int'(num_rows);
          m_drain_left <= DRAIN;
        end
      end
    end else if (m_rows_left > 0) begin
      if (in_valid && !stall) begin
        m_rows_fed  <= m_rows_fed + 1;
        m_rows_left <= m_rows_left - 1;
        if (m_rows_left == 1 && m_drain_left == 0) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end else if (!stall) begin
      m_drain_left <= m_drain_left - 1;
      if (m_drain_left == 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
    end
  end

  logic e_feeding, e_draining;
  logic [4:0] e_flags, a_flags;
  assign e_feeding  = m_active && (m_rows_left > 0);
  assign e_draining = m_active && (m_rows_left == 0);
  assign e_flags = {e_feeding && !stall,
                    (e_feeding && in_valid && !stall) || (e_draining && !stall),
                    e_draining, m_active || m_done, m_done};
  assign a_flags = {in_ready, fifo_en, feed_zero, busy, tile_done};

  always @(negedge clk) begin
    check("flags{rdy,en,zero,busy,done}", a_flags, e_flags);
    check("rows_fed_model", int'(rows_fed), m_rows_fed);
  end

  // Per-cycle stimulus for run_tile; index 1 is the start cycle.
  bit start_pat[64];
  bit stall_pat[64];
  bit valid_pat[64];

  task automatic default_pats();
    for (int i = 0; i < 64; i++) begin
      start_pat[i] = (i == 1);
      stall_pat[i] = 1'b0;
      valid_pat[i] = 1'b1;
    end
  endtask

  // Called at posedge+1; returns cycle number (start cycle = 1) of tile_done, or 0 on timeout.
  task automatic run_tile(input int nr, input int budget, output int done_cyc,
                          output int n_data, output int n_zero);
    done_cyc = 0;
    n_data   = 0;
    n_zero   = 0;
    num_rows = CNT_W'(nr);
    for (int c = 1; c <= budget && done_cyc == 0; c++) begin
      start    = (c < 64) ? start_pat[c] : 1'b0;
      stall    = (c < 64) ? stall_pat[c] : 1'b0;
      in_valid = (c < 64) ? valid_pat[c] : 1'b1;
      @(negedge clk);
      if (fifo_en && !feed_zero) n_data++;
      if (fifo_en && feed_zero) n_zero++;
      if (tile_done) done_cyc = c;
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
  endtask

  int dc, nd, nz, extra;

  initial begin
    #2;
    check("reset_outputs", {in_ready, fifo_en, feed_zero, busy, tile_done}, 0);
    check("reset_rows_fed", rows_fed, 0);
    @(posedge clk);
    @(posedge clk);
    #3 nrst = 1'b1;
    @(posedge clk);
    #1;

    // Basic tile, no stall: 4 data rows, 31 zero fills, done in cycle 37.
    default_pats();
    run_tile(4, 100, dc, nd, nz);
    check("t1_done_cycle", dc, 37);
    check("t1_data_rows", nd, 4);
    check("t1_zero_fills", nz, 31);
    check("t1_rows_fed", rows_fed, 4);

    // Two stall cycles after row 2 delay completion by exactly 2.
    default_pats();
    stall_pat[4] = 1'b1;
    stall_pat[5] = 1'b1;
    run_tile(3, 100, dc, nd, nz);
    check("t2_done_cycle", dc, 38);
    check("t2_data_rows", nd, 3);
    check("t2_zero_fills", nz, 31);

    // Empty tile goes straight to done.
    default_pats();
    run_tile(0, 20, dc, nd, nz);
    check("t3_done_cycle", dc, 2);
    check("t3_fifo_en_count", nd + nz, 0);
    check("t3_rows_fed", rows_fed, 0);

    // Start pulsed during FEED is dropped.
    default_pats();
    start_pat[3] = 1'b1;
    run_tile(2, 100, dc, nd, nz);
    check("t4_done_cycle", dc, 35);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (tile_done || busy) extra++;
    end
    @(posedge clk);
    #1;
    check("t4_no_extra_tile", extra, 0);

    // Gapped in_valid: rows taken only on valid cycles.
    default_pats();
    valid_pat[2] = 1'b1;
    valid_pat[3] = 1'b0;
    valid_pat[4] = 1'b1;
    valid_pat[5] = 1'b0;
    run_tile(2, 100, dc, nd, nz);
    check("t5_done_cycle", dc, 36);
    check("t5_data_rows", nd, 2);
    check("t5_rows_fed", rows_fed, 2);

    // Asynchronous reset during the 10th drain cycle (cycle 15).
    num_rows = CNT_W'(4);
    start    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (13) @(posedge clk);
    #3;
    check("t6_pre_reset_zero", {feed_zero, busy}, 2'b11);
    nrst = 1'b0;
    #1;
    check("t6_async_outputs", {in_ready, fifo_en, feed_zero, busy, tile_done}, 0);
    check("t6_async_rows_fed", rows_fed, 0);
    extra = 0;
    repeat (2) begin
      @(negedge clk);
      if (tile_done) extra++;
    end
    check("t6_no_done_in_reset", extra, 0);
    @(posedge clk);
    #3 nrst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    default_pats();
    run_tile(2, 100, dc, nd, nz);
    check("t6_fresh_done_cycle", dc, 35);
    check("t6_fresh_data_rows", nd, 2);

    // Full-scale row count completes without counter wrap.
    default_pats();
    run_tile(65535, 70000, dc, nd, nz);
    check("t7_done_cycle", dc, 65535 + DRAIN + 2);
    check("t7_data_rows", nd, 65535);
    check("t7_rows_fed", rows_fed, 65535);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_feed_ctrl.md
INPUT_FEED_CTRL -- requirements
Module: input_feed_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning systolic array dimension (lanes of the input array).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the row counters.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default N-1, meaning zero-fill cycles issued after the last row to flush the skew buffers.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port nrst, input, 1, meaning the asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1, meaning a tile start request, sampled only in IDLE.
REQ-007 The block SHALL have port num_rows, input, CNT_W, meaning rows in the tile, latched when start is accepted.
REQ-008 The block SHALL have port in_valid, input, 1, meaning the upstream (AXI side) row vector is valid.
REQ-009 The block SHALL have port in_ready, output, 1, meaning the controller accepts a row this cycle.
REQ-010 The block SHALL have port stall, input, 1, meaning the downstream array cannot advance this cycle.
REQ-011 The block SHALL have port fifo_en, output, 1, meaning advance/write strobe to the input array.
REQ-012 The block SHALL have port feed_zero, output, 1, meaning the datapath drives zeros instead of upstream data.
REQ-013 The block SHALL have port busy, output, 1, meaning the state is not IDLE.
REQ-014 The block SHALL have port tile_done, output, 1, meaning a one-cycle pulse when the tile is fully flushed.
REQ-015 The block SHALL have port rows_fed, output, CNT_W, meaning rows accepted in the current or last tile.

Function
REQ-016 The FSM SHALL have the states IDLE, FEED, DRAIN and DONE; the state register SHALL be the only source of busy (busy = state != IDLE).
REQ-017 In IDLE, a start with num_rows != 0 SHALL latch num_rows, clear rows_fed and go to FEED on the next edge.
REQ-018 In IDLE, a start with num_rows == 0 SHALL go directly to DONE, with rows_fed cleared.
REQ-019 In FEED: in_ready = !stall; fifo_en = in_valid & in_ready; feed_zero = 0.
REQ-020 Each accepted row (fifo_en=1 in FEED) SHALL increment rows_fed by 1; rows_fed SHALL be registered and visible the cycle after acceptance.
REQ-021 Acceptance of row number num_rows SHALL transition FEED->DRAIN, or FEED->DONE when DRAIN_CYCLES == 0.
REQ-022 In DRAIN: in_ready = 0; feed_zero = 1; fifo_en = !stall; the drain counter SHALL increment only when fifo_en = 1.
REQ-023 After exactly DRAIN_CYCLES non-stalled DRAIN cycles, the FSM SHALL go DRAIN->DONE.
REQ-024 DONE SHALL last exactly one cycle with tile_done = 1, then go to IDLE; the minimum start-to-start interval is therefore num_rows + DRAIN_CYCLES + 2 cycles.
REQ-025 A start asserted while busy SHALL be ignored; it is not queued.
REQ-026 Stall SHALL freeze all counters and the state in FEED and DRAIN; in_ready and fifo_en SHALL be 0 while stall = 1.
REQ-027 in_valid without in_ready SHALL have no effect; upstream holds its data.
REQ-028 Outputs in_ready, fifo_en and feed_zero SHALL be combinational from the state and inputs; tile_done, busy and rows_fed SHALL be registered.
REQ-029 Counters SHALL be CNT_W bits, and num_rows = 2^CNT_W-1 SHALL complete without wrap.

Reset
REQ-030 On nrst = 0, the state SHALL go to IDLE immediately, and rows_fed, the drain counter and the latched num_rows SHALL be 0.
REQ-031 During and after reset, in_ready, fifo_en, feed_zero, busy and tile_done SHALL be 0.
REQ-032 Reset mid-FEED or mid-DRAIN SHALL abort the tile with no tile_done pulse; the first start after reset release SHALL begin a fresh tile.

Structure
REQ-033 Package input_ctrl_pkg SHALL hold the state enum (feed_state_t) and the defaults for N and CNT_W.
REQ-034 One sub-module, feed_counter (a CNT_W up-counter with clear, enable and a terminal-compare output), SHALL be instantiated twice: once for rows and once for drain.

Verification
REQ-035 Scenario: num_rows=4, N=32, in_valid held at 1, no stall -> 4 fifo_en with feed_zero=0, then 31 with feed_zero=1, then tile_done on cycle 37 after start, and rows_fed=4.
REQ-036 Scenario: num_rows=3, stall=1 for 2 cycles after row 2 -> in_ready=0 and fifo_en=0 for those 2 cycles, completion delayed by exactly 2 cycles.
REQ-037 Scenario: num_rows=0 -> tile_done 2 cycles after start with no fifo_en; a start pulsed during FEED is ignored and produces no extra tile.
REQ-038 Scenario: nrst asserted in DRAIN cycle 10 -> all outputs 0 asynchronously, no tile_done; a new start with num_rows=2 completes normally.
REQ-039 Scenario: in_valid toggling 1,0,1,0 with num_rows=2 -> rows_fed increments only on in_valid=1 cycles; DRAIN is entered after the second accepted row.
